uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter sharing one byte-wide UART transmitter among NUM_REQ requesters.
//  Grants are packet-locked: the winner keeps the transmitter until its last byte is accepted,
//  an idle timeout expires, or the packet length limit is reached.
//  Sits between message sources (status, debug, echo) and the serial UART TX byte interface.
// PARAMETERS
//  NUM_REQ       4    number of requesters, 2..8
//  MAX_PKT       64   max bytes per grant; reaching it forces release
//  IDLE_TIMEOUT  255  cycles the granted requester may leave req_valid low mid-packet before abort
// PORTS
//  clk           in   1          system clock; all logic on posedge
//  rst_n         in   1          asynchronous active-low reset
//  req_valid     in   NUM_REQ    per-requester byte valid
//  req_data      in   8*NUM_REQ  per-requester byte; requester i uses bits [8*i+7:8*i]
//  req_last      in   NUM_REQ    marks the final byte of a packet
//  req_ready     out  NUM_REQ    byte accepted from requester i when req_valid[i] & req_ready[i]
//  tx_valid      out  1          byte valid to the UART transmitter
//  tx_data       out  8          byte to the UART transmitter
//  tx_ready      in   1          transmitter accepts tx_data when tx_valid & tx_ready
//  grant_id      out  3          index of the current/last grantee
//  busy          out  1          high in GRANT and DRAIN
//  err_abort     out  1          one-cycle pulse on timeout or MAX_PKT release
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, req_ready=0, tx_valid=0, tx_data=0, grant_id=0, busy=0,
//   err_abort=0, byte_cnt=0, idle_cnt=0.
//  Output register: tx_valid/tx_data form a one-entry register.
//   - Loaded on each accepted byte.
//   - Cleared when tx_valid & tx_ready and no new byte is loaded in the same cycle.
//   - Simultaneous drain and load: the register holds the new byte with tx_valid=1.
//  States:
//   IDLE: scan req_valid from rr_ptr upward with wrap; the first set bit g wins.
//     - On a winner: grant_id<=g, byte_cnt<=0, idle_cnt<=0, go GRANT next edge.
//     - No requester: stay in IDLE.
//     - Arbitration latency: 1 cycle.
//   GRANT: req_ready[g] = ~tx_valid | tx_ready, combinational. All other req_ready bits are 0.
//     - Accepted byte: load output register, byte_cnt++, idle_cnt<=0.
//     - Accepted byte with req_last: go DRAIN.
//     - Accepted byte with byte_cnt==MAX_PKT-1 and req_last=0: go DRAIN, err_abort pulse.
//     - req_valid[g]==0: idle_cnt++. At idle_cnt==IDLE_TIMEOUT-1: go DRAIN, err_abort pulse.
//     - Stalls from tx_ready=0 do not count toward the timeout.
//   DRAIN: req_ready=0.
//     - When tx_valid==0, or tx_valid & tx_ready: go IDLE, rr_ptr<=(g+1) mod NUM_REQ.
//  Fairness: a requester that just released has lowest priority for the next arbitration.
//  Aborted requester: it must restart its packet. Bytes it has not yet had accepted are untouched.
//  Requests during GRANT/DRAIN are ignored until IDLE. No bytes are lost or duplicated.
//  byte_cnt is $clog2(MAX_PKT+1) bits. idle_cnt is $clog2(IDLE_TIMEOUT+1) bits. Neither counter wraps.
//  Reset mid-packet: all state clears immediately; tx_valid drops asynchronously.
//  Throughput: with tx_ready held high, one byte per cycle in GRANT.
//   Per-packet overhead is 1 arbitration cycle plus 1 DRAIN cycle.
// TESTING
//  1. Single requester: req0 sends 0x48,0x69,0x0A(last) with tx_ready=1.
//     -> tx_data 0x48,0x69,0x0A on consecutive cycles; grant_id=0; busy drops after DRAIN.
//  2. req0..req3 all valid with 2-byte packets.
//     -> grant order 0,1,2,3; next round starts at 0; no interleaving within a packet.
//  3. req1 sends 3 bytes while tx_ready toggles 1,0,0,1.
//     -> req_ready[1] follows ~tx_valid|tx_ready; tx_data stable while stalled; no err_abort.
//  4. req2 sends 1 byte, no last, then drops valid.
//     -> err_abort pulse after IDLE_TIMEOUT=255 cycles; then IDLE; next grant goes to req3 if valid.
//  5. req0 streams 70 bytes, never asserts last.
//     -> exactly 64 bytes forwarded; err_abort pulses; rr_ptr advances to 1.
//  6. rst_n low during byte 2 of a packet, then high.
//     -> all outputs at reset values; new arbitration starts from rr_ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART transmitter among
// NUM_REQ requesters. A grant is held for a whole packet. It is released on
// the last byte, after IDLE_TIMEOUT idle cycles, or after MAX_PKT bytes.
//
// Handshake: a byte moves on any interface in a cycle where valid & ready
// are both high at the clock edge. A source holds valid and data stable
// until the transfer. ready may depend combinationally on the downstream
// side: req_ready[g] = ~tx_valid | tx_ready. tx_valid never depends on
// tx_ready.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_PKT      = 64,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 err_abort,
  output logic [1:0]           state_dbg
);

  localparam int BCW = $clog2(MAX_PKT + 1);
  localparam int ICW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       rr_ptr, rr_d;
  logic [2:0]       grant_d;
  logic [BCW-1:0]   byte_cnt, byte_d;
  logic [ICW-1:0]   idle_cnt, idle_d;
  logic             tx_valid_d;
  logic [7:0]       tx_data_d;
  logic             abort_d;
  logic             gnt_ready;
  logic             win_found;
  logic [2:0]       win_id;
  logic [3:0]       scan_idx;
  logic             cur_valid;
  logic             cur_last;
  logic [7:0]       cur_data;

  // Round-robin scan: the first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + 4'(k);
      if (scan_idx >= 4'(NUM_REQ)) scan_idx = scan_idx - 4'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && req_valid[i] && (scan_idx == 4'(i))) begin
          win_found = 1'b1;
          win_id    = 3'(i);
        end
      end
    end
  end

  // Select the current grantee's valid/last/data lanes.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 3'(i)) begin
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
        cur_data  = req_data[8*i +: 8];
      end
    end
  end

  // Only the grantee sees ready, and only while the output register can take a byte.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = gnt_ready && (grant_id == 3'(i));
    end
  end

  // Next-state and datapath decisions for IDLE / GRANT / DRAIN.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_ptr;
    grant_d    = grant_id;
    byte_d     = byte_cnt;
    idle_d     = idle_cnt;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    abort_d    = 1'b0;
    gnt_ready  = 1'b0;

    // The output register empties on a drain unless a new byte loads below.
    if (tx_valid && tx_ready) tx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_id;
          byte_d  = '0;
          idle_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        gnt_ready = ~tx_valid | tx_ready;
        if (cur_valid && gnt_ready) begin
          tx_valid_d = 1'b1;
          tx_data_d  = cur_data;
          byte_d     = byte_cnt + BCW'(1);
          idle_d     = '0;
          if (cur_last) begin
            state_d = S_DRAIN;
          end else if (byte_cnt == BCW'(MAX_PKT - 1)) begin
            state_d = S_DRAIN;
            abort_d = 1'b1;
          end
        end else if (!cur_valid) begin
          // Only cycles with valid low count; back-pressure stalls do not.
          idle_d = idle_cnt + ICW'(1);
          if (idle_cnt == ICW'(IDLE_TIMEOUT - 1)) begin
            state_d = S_DRAIN;
            abort_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!tx_valid || tx_ready) begin
          state_d = S_IDLE;
          rr_d    = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Arbitration, counter and output-register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      byte_cnt  <= '0;
      idle_cnt  <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      err_abort <= 1'b0;
    end else begin
      rr_ptr    <= rr_d;
      grant_id  <= grant_d;
      byte_cnt  <= byte_d;
      idle_cnt  <= idle_d;
      tx_valid  <= tx_valid_d;
      tx_data   <= tx_data_d;
      err_abort <= abort_d;
    end
  end

  assign busy      = (state_q == S_GRANT) || (state_q == S_DRAIN);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. Requesters are per-source byte queues.
// Expected traffic is built at packet level. Each arbitration picks the
// first pending source from the round-robin pointer. That source forwards
// bytes until its last flag, MAX_PKT bytes, or its queue runs dry.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int MAX_PKT      = 64;
  localparam int IDLE_TIMEOUT = 255;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 err_abort;
  logic [1:0]           state_dbg;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_PKT(MAX_PKT), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .err_abort(err_abort),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  int         total = 0;
  int         bad   = 0;
  logic [8:0] src_q [NUM_REQ][$];   // {last, data} per requester
  logic [10:0] exp_q[$];            // {grant_id, data}
  int         model_rr;
  int         exp_abort;
  int         abort_cnt;
  int         abort_cycle;
  int         cycle = 0;
  int         acc_total;
  int         acc_per   [NUM_REQ];
  int         acc_cycle [NUM_REQ];
  int         tx_cycles[$];
  int         tx_mode;
  logic       rdy_pat[$];
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_abort;

  // Driver: present each queue head, pick tx_ready by mode.
  task automatic drive_inputs();
    logic [8:0] b;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = b[7:0];
        req_last[i]        = b[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'($urandom);
        req_last[i]        = 1'b0;
      end
    end
    case (tx_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(0, 3) != 0);
      default: tx_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
    endcase
  endtask

  task automatic hold_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    tx_ready   = 1'b0;
    prev_stall = 1'b0;
    prev_abort = 1'b0;
    prev_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    model_rr = 0;
  endtask

  task automatic do_reset();
    hold_reset();
    release_reset();
  endtask

  task automatic prep();
    abort_cnt   = 0;
    abort_cycle = 0;
    acc_total   = 0;
    tx_cycles.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      acc_per[i]   = 0;
      acc_cycle[i] = 0;
    end
  endtask

  task automatic push_pkt(input int r, input int len, input bit with_last);
    for (int k = 0; k < len; k++)
      src_q[r].push_back({(with_last && (k == len - 1)), 8'($urandom)});
  endtask

  // Reference model: packet-level round robin over the pending queues.
  task automatic build_expected();
    logic [8:0] m [NUM_REQ][$];
    logic [8:0] b;
    int g, cnt, idx;
    bit ended;
    for (int i = 0; i < NUM_REQ; i++) m[i] = src_q[i];
    exp_abort = 0;
    while (1) begin
      g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (model_rr + k) % NUM_REQ;
        if (g < 0 && m[idx].size() > 0) g = idx;
      end
      if (g < 0) break;
      cnt   = 0;
      ended = 0;
      while (!ended) begin
        b = m[g].pop_front();
        exp_q.push_back({3'(g), b[7:0]});
        cnt++;
        if (b[8]) begin
          ended = 1;
        end else if (cnt == MAX_PKT || m[g].size() == 0) begin
          ended = 1;
          exp_abort++;
          m[g].delete();
        end
      end
      model_rr = (g + 1) % NUM_REQ;
    end
  endtask

  // Cycle loop with monitor/scoreboard; returns when all traffic is done,
  // after stop_acc accepted bytes (if nonzero), or on the cycle budget.
  task automatic run(input int max_cycles, input int stop_acc);
    logic [NUM_REQ-1:0] acc;
    logic [10:0] e;
    bit flush, src_empty;
    logic [2:0] flush_id;
    int n;
    n = 0;
    flush = 0;
    flush_id = '0;
    while (1) begin
      @(negedge clk);
      cycle++;
      n++;
      acc = req_valid & req_ready;
      if (req_ready !== '0) begin
        total++;
        if (!busy || req_ready !== (4'd1 << grant_id) || !(~tx_valid | tx_ready)) begin
          bad++;
          $display("FAIL ready_legal: req_ready=%b grant_id=%0d tx_valid=%b tx_ready=%b busy=%b state=%0d, required one-hot grant bit with ~tx_valid|tx_ready",
                   req_ready, grant_id, tx_valid, tx_ready, busy, state_dbg);
        end
      end
      if (prev_stall) begin
        total++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          bad++;
          $display("FAIL tx_hold: tx_valid=%b tx_data=%h, required 1 and %h", tx_valid, tx_data, prev_data);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
        tx_cycles.push_back(cycle);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL tx_extra: got id=%0d data=%h, required no transfer", grant_id, tx_data);
        end else begin
          e = exp_q.pop_front();
          if ({grant_id, tx_data} !== e) begin
            bad++;
            $display("FAIL tx_byte: got id=%0d data=%h, required id=%0d data=%h", grant_id, tx_data, e[10:8], e[7:0]);
          end
        end
      end
      if (err_abort) begin
        total++;
        if (prev_abort) begin
          bad++;
          $display("FAIL abort_width: err_abort high %0d cycles in a row, required 1", 2);
        end
        abort_cnt++;
        abort_cycle = cycle;
        flush = 1;
        flush_id = grant_id;
      end
      prev_abort = err_abort;
      if (acc != '0) acc_total++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          acc_per[i]++;
          acc_cycle[i] = cycle;
        end
      end
      src_empty = 1;
      for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() > 0) src_empty = 0;
      if (stop_acc == 0 && src_empty && exp_q.size() == 0 && !busy && !tx_valid) return;
      if (n >= max_cycles) begin
        total++;
        bad++;
        $display("FAIL run_timeout: %0d cycles, %0d expected bytes left, required completion", n, exp_q.size());
        return;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (acc[i]) void'(src_q[i].pop_front());
      if (flush) begin
        src_q[flush_id].delete();
        flush = 0;
      end
      drive_inputs();
      if (stop_acc > 0 && acc_total >= stop_acc) return;
    end
  endtask

  task automatic check_aborts(input string name);
    total++;
    if (abort_cnt !== exp_abort) begin
      bad++;
      $display("FAIL %s: err_abort pulses=%0d, required %0d", name, abort_cnt, exp_abort);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (req_ready !== '0 || tx_valid !== 1'b0 || tx_data !== 8'h00 ||
        grant_id !== 3'd0 || busy !== 1'b0 || err_abort !== 1'b0) begin
      bad++;
      $display("FAIL %s: ready=%b tx_valid=%b tx_data=%h grant=%0d busy=%b abort=%b, required all zero",
               name, req_ready, tx_valid, tx_data, grant_id, busy, err_abort);
    end
  endtask

  task automatic test_reset();
    hold_reset();
    tx_mode = 0;
    @(negedge clk);
    check_reset_outputs("reset_hold");
    release_reset();
    check_reset_outputs("reset_release");
    @(negedge clk);
    check_reset_outputs("reset_idle");
  endtask

  task automatic test_single();
    int c0;
    do_reset();
    prep();
    src_q[0].push_back(9'h048);
    src_q[0].push_back(9'h069);
    src_q[0].push_back(9'h10A);
    build_expected();
    tx_mode = 0;
    c0 = cycle;
    drive_inputs();
    run(200, 0);
    check_aborts("single_abort");
    total++;
    if (tx_cycles.size() != 3) begin
      bad++;
      $display("FAIL single_count: transfers=%0d, required 3", tx_cycles.size());
    end else begin
      total++;
      if (tx_cycles[0] != c0 + 2 || tx_cycles[2] != c0 + 4) begin
        bad++;
        $display("FAIL single_timing: first=%0d last=%0d, required %0d and %0d", tx_cycles[0], tx_cycles[2], c0 + 2, c0 + 4);
      end
    end
    total++;
    if (grant_id !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_end: grant_id=%0d busy=%b, required 0 and 0", grant_id, busy);
    end
  endtask

  task automatic test_round_robin();
    int c0;
    do_reset();
    prep();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++) push_pkt(i, 2, 1);
    build_expected();
    tx_mode = 0;
    c0 = cycle;
    drive_inputs();
    run(500, 0);
    check_aborts("rr_abort");
    total++;
    if (tx_cycles.size() != 16) begin
      bad++;
      $display("FAIL rr_count: transfers=%0d, required 16", tx_cycles.size());
    end else begin
      total++;
      if (tx_cycles[0] != c0 + 2 || tx_cycles[15] != c0 + 31) begin
        bad++;
        $display("FAIL rr_throughput: first=%0d last=%0d, required %0d and %0d", tx_cycles[0], tx_cycles[15], c0 + 2, c0 + 31);
      end
    end
  endtask

  task automatic test_stall();
    prep();
    push_pkt(1, 3, 1);
    build_expected();
    rdy_pat.delete();
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b1);
    tx_mode = 2;
    drive_inputs();
    run(200, 0);
    check_aborts("stall_abort");
    total++;
    if (acc_per[1] != 3) begin
      bad++;
      $display("FAIL stall_count: accepted=%0d, required 3", acc_per[1]);
    end
  endtask

  task automatic test_timeout();
    prep();
    src_q[2].push_back(9'h05A);
    push_pkt(3, 2, 1);
    push_pkt(0, 1, 1);
    build_expected();
    tx_mode = 1;
    drive_inputs();
    run(2000, 0);
    check_aborts("timeout_abort");
    total++;
    if (abort_cycle - acc_cycle[2] != IDLE_TIMEOUT + 1) begin
      bad++;
      $display("FAIL timeout_delay: abort %0d cycles after last byte, required %0d", abort_cycle - acc_cycle[2], IDLE_TIMEOUT + 1);
    end
  endtask

  task automatic test_max_pkt();
    do_reset();
    prep();
    push_pkt(0, 70, 0);
    push_pkt(1, 1, 1);
    build_expected();
    tx_mode = 1;
    drive_inputs();
    run(2000, 0);
    check_aborts("maxpkt_abort");
    total++;
    if (acc_per[0] != MAX_PKT || acc_per[1] != 1) begin
      bad++;
      $display("FAIL maxpkt_count: req0=%0d req1=%0d, required %0d and 1", acc_per[0], acc_per[1], MAX_PKT);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    prep();
    push_pkt(0, 5, 1);
    build_expected();
    tx_mode = 0;
    drive_inputs();
    run(100, 2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_async");
    hold_reset();
    release_reset();
    check_reset_outputs("reset_mid_after");
    prep();
    push_pkt(1, 2, 1);
    push_pkt(0, 2, 1);
    build_expected();
    tx_mode = 1;
    drive_inputs();
    run(300, 0);
    check_aborts("reset_mid_abort");
  endtask

  task automatic test_back_to_back();
    int npk;
    for (int it = 0; it < 4; it++) begin
      prep();
      npk = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        for (int p = 0; p < $urandom_range(0, 2); p++) begin
          push_pkt(i, $urandom_range(1, 6), 1);
          npk++;
        end
      end
      if (npk == 0) push_pkt($urandom_range(0, NUM_REQ - 1), 3, 1);
      build_expected();
      tx_mode = 1;
      drive_inputs();
      run(3000, 0);
      check_aborts("random_abort");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_timeout();
    test_max_pkt();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
